// File: rtl/flappy_pkg.sv
// Shared game-wide types and screen geometry for the flappy pipeline.
// Y_GROUND is also used by color_mapper to draw the ground band.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DEAD   = 2'd2
    } bird_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int Y_GROUND = 400;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// o_pulse is a one-Clk pulse three Clk edges after i_async rises.
module edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_pulse;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_pulse  <= r_sync & ~r_sync_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/bird_physics.sv
// Bird position/velocity integrator, updated once per video frame, with
// ground/ceiling clamping and an IDLE/FLYING/DEAD state machine.
module bird_physics
    import flappy_pkg::*;
#(
    parameter int X_POS    = 160,
    parameter int Y_START  = 240,
    parameter int Y_GROUND = flappy_pkg::Y_GROUND,
    parameter int SIZE     = 4,
    parameter int FLAP_VEL = 6,
    parameter int VMAX     = 8,
    parameter int GRAV_DIV = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              flap,
    output logic [9:0]        BirdX,
    output logic [9:0]        BirdY,
    output logic [9:0]        Bird_size,
    output logic [1:0]        bird_state,
    output logic              dead,
    output logic signed [7:0] bird_vel
);

    localparam logic signed [7:0]  LP_FLAP_V = 8'(-FLAP_VEL);
    localparam logic signed [7:0]  LP_VMAX   = 8'(VMAX);
    localparam logic signed [10:0] LP_SIZE   = 11'(SIZE);
    localparam logic signed [10:0] LP_GROUND = 11'(Y_GROUND);
    localparam logic [7:0]         LP_CNT_TOP = 8'(GRAV_DIV - 1);

    function automatic logic signed [7:0] vel_inc_sat(input logic signed [7:0] v);
        if (v >= LP_VMAX)
            return LP_VMAX;
        else
            return v + 8'sd1;
    endfunction

    logic w_frame_tick;
    logic w_flap_pulse;
    logic w_flap;

    bird_state_t      r_state;
    logic [9:0]       r_bird_y;
    logic signed [7:0] r_vel;
    logic [7:0]       r_grav_cnt;
    logic             r_flap_pend;
    logic             r_dead;

    logic signed [7:0]  w_vel_new;
    logic [7:0]         w_cnt_new;
    logic signed [10:0] w_y_next;
    logic signed [10:0] w_y_bottom;
    logic signed [10:0] w_y_top;

    edge_sync u_frame_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_async (frame_clk),
        .o_pulse (w_frame_tick)
    );

    edge_sync u_flap_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_async (flap),
        .o_pulse (w_flap_pulse)
    );

    // A flap edge landing on the tick cycle is folded into that tick.
    assign w_flap = r_flap_pend | w_flap_pulse;

    always_comb begin
        w_vel_new = r_vel;
        w_cnt_new = r_grav_cnt;
        if (w_flap) begin
            w_vel_new = LP_FLAP_V;
            w_cnt_new = 8'd0;
        end else if (r_grav_cnt == LP_CNT_TOP) begin
            w_vel_new = vel_inc_sat(r_vel);
            w_cnt_new = 8'd0;
        end else begin
            w_cnt_new = r_grav_cnt + 8'd1;
        end
        w_y_next   = $signed({1'b0, r_bird_y}) + {{3{w_vel_new[7]}}, w_vel_new};
        w_y_bottom = w_y_next + LP_SIZE;
        w_y_top    = w_y_next - LP_SIZE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_bird_y    <= 10'(Y_START);
            r_vel       <= 8'sd0;
            r_grav_cnt  <= 8'd0;
            r_flap_pend <= 1'b0;
            r_dead      <= 1'b0;
        end else begin
            r_flap_pend <= w_frame_tick ? 1'b0 : (r_flap_pend | w_flap_pulse);
            if (w_frame_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_flap) begin
                            r_state    <= FLYING;
                            r_vel      <= LP_FLAP_V;
                            r_grav_cnt <= 8'd0;
                            r_bird_y   <= 10'(Y_START - FLAP_VEL);
                        end
                    end
                    FLYING: begin
                        r_grav_cnt <= w_cnt_new;
                        if (w_y_bottom >= LP_GROUND) begin
                            r_bird_y <= 10'(Y_GROUND - SIZE);
                            r_vel    <= 8'sd0;
                            r_state  <= DEAD;
                            r_dead   <= 1'b1;
                        end else if (w_y_top < 11'sd0) begin
                            r_bird_y <= 10'(SIZE);
                            r_vel    <= 8'sd0;
                        end else begin
                            r_bird_y <= w_y_next[9:0];
                            r_vel    <= w_vel_new;
                        end
                    end
                    DEAD: begin
                        if (w_flap) begin
                            r_state    <= IDLE;
                            r_bird_y   <= 10'(Y_START);
                            r_vel      <= 8'sd0;
                            r_grav_cnt <= 8'd0;
                            r_dead     <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign BirdX      = 10'(X_POS);
    assign Bird_size  = 10'(SIZE);
    assign BirdY      = r_bird_y;
    assign bird_state = r_state;
    assign dead       = r_dead;
    assign bird_vel   = r_vel;

endmodule
